// File: rtl/move_backtrack_sequencer.sv
// Replays an ant's move stack in reverse to walk it back toward home, clamping at grid edges.
// Optional BACKTRACK_HOLD_EN adds a Hold input that parks the FSM in CHECK.
module move_backtrack_sequencer #(
    parameter int GRID_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Load,
    input  logic [GRID_W-1:0] Load_x,
    input  logic [GRID_W-1:0] Load_y,
    input  logic              Stack_empty,
    input  logic [2:0]        Move_in,
`ifdef BACKTRACK_HOLD_EN
    input  logic              Hold,
`endif
    output logic              Pop,
    output logic [GRID_W-1:0] Pos_x,
    output logic [GRID_W-1:0] Pos_y,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  Step_cnt,
    output logic              Edge_err
);

    typedef enum logic [2:0] {IDLE, CHECK, POP, WAIT, APPLY, DONE} state_t;

    state_t            state;
    logic [2:0]        move_q;
    logic [2:0]        rev;
    logic              hold;
    logic              x_up, x_dn, y_up, y_dn;
    logic              clamp;
    logic [GRID_W-1:0] next_x, next_y;

`ifdef BACKTRACK_HOLD_EN
    assign hold = Hold;
`else
    assign hold = 1'b0;
`endif

    // Undo a move by applying the opposite compass direction.
    always_comb begin
        rev    = move_q + 3'd4;
        x_up   = rev inside {3'd1, 3'd2, 3'd3};
        x_dn   = rev inside {3'd5, 3'd6, 3'd7};
        y_up   = rev inside {3'd7, 3'd0, 3'd1};
        y_dn   = rev inside {3'd3, 3'd4, 3'd5};
        next_x = Pos_x;
        next_y = Pos_y;
        clamp  = 1'b0;
        if (x_up) begin
            if (Pos_x == '1) clamp = 1'b1;
            else             next_x = Pos_x + GRID_W'(1);
        end
        if (x_dn) begin
            if (Pos_x == '0) clamp = 1'b1;
            else             next_x = Pos_x - GRID_W'(1);
        end
        if (y_up) begin
            if (Pos_y == '1) clamp = 1'b1;
            else             next_y = Pos_y + GRID_W'(1);
        end
        if (y_dn) begin
            if (Pos_y == '0) clamp = 1'b1;
            else             next_y = Pos_y - GRID_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            move_q   <= '0;
            Pop      <= 1'b0;
            Pos_x    <= '0;
            Pos_y    <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Step_cnt <= '0;
            Edge_err <= 1'b0;
        end else begin
            Pop  <= 1'b0;
            Done <= 1'b0;
            if (state != IDLE && Abort) begin
                state <= IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Load) begin
                            Pos_x <= Load_x;
                            Pos_y <= Load_y;
                        end
                        if (Start) begin
                            state    <= CHECK;
                            Busy     <= 1'b1;
                            Step_cnt <= '0;
                            Edge_err <= 1'b0;
                        end
                    end
                    CHECK: begin
                        if (!hold) begin
                            if (Stack_empty) begin
                                state <= DONE;
                                Done  <= 1'b1;
                            end else begin
                                state <= POP;
                                Pop   <= 1'b1;
                            end
                        end
                    end
                    POP: state <= WAIT;
                    WAIT: begin
                        move_q <= Move_in;
                        state  <= APPLY;
                    end
                    APPLY: begin
                        Pos_x <= next_x;
                        Pos_y <= next_y;
                        if (clamp) Edge_err <= 1'b1;
                        if (Step_cnt != '1) Step_cnt <= Step_cnt + CNT_W'(1);
                        state <= CHECK;
                    end
                    DONE: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_backtrack_sequencer.sv
// Bench for move_backtrack_sequencer: a queue models the move stack, an integer walk models the ant.
module tb_move_backtrack_sequencer;

    localparam int GW   = 5;
    localparam int CW   = 6;
    localparam int GMAX = (1 << GW) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic          Load = 1'b0;
    logic [GW-1:0] Load_x = '0;
    logic [GW-1:0] Load_y = '0;
    logic          Stack_empty = 1'b1;
    logic [2:0]    Move_in = '0;
`ifdef BACKTRACK_HOLD_EN
    logic          Hold = 1'b0;
`endif
    logic          Pop;
    logic [GW-1:0] Pos_x;
    logic [GW-1:0] Pos_y;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Step_cnt;
    logic          Edge_err;

    move_backtrack_sequencer #(.GRID_W(GW), .CNT_W(CW)) dut (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .Abort(Abort), .Load(Load),
        .Load_x(Load_x), .Load_y(Load_y), .Stack_empty(Stack_empty), .Move_in(Move_in),
`ifdef BACKTRACK_HOLD_EN
        .Hold(Hold),
`endif
        .Pop(Pop), .Pos_x(Pos_x), .Pos_y(Pos_y), .Busy(Busy), .Done(Done),
        .Step_cnt(Step_cnt), .Edge_err(Edge_err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stack[$];
    int ex[$], ey[$], ee[$];
    // Move code -> displacement of the original (forward) move.
    int dx_of[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dy_of[8] = '{1, 1, 0, -1, -1, -1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; the stack answers a pop with the top code during the next cycle.
    task automatic tick();
        logic pop_seen;
        pop_seen = Pop;
        @(posedge Clk);
        #1;
        if (pop_seen && stack.size() != 0) Move_in = 3'(stack.pop_back());
        Stack_empty = (stack.size() == 0);
    endtask

    // Expected position/error after k undone moves, k = 0..n.
    task automatic build_model(input int x0, input int y0);
        int q[$];
        int x, y, e, c;
        q = stack;
        x = x0; y = y0; e = 0;
        ex = {x}; ey = {y}; ee = {e};
        while (q.size() != 0) begin
            c = q.pop_back();
            x = x - dx_of[c];
            y = y - dy_of[c];
            if (x < 0)    begin x = 0;    e = 1; end
            if (x > GMAX) begin x = GMAX; e = 1; end
            if (y < 0)    begin y = 0;    e = 1; end
            if (y > GMAX) begin y = GMAX; e = 1; end
            ex.push_back(x); ey.push_back(y); ee.push_back(e);
        end
    endtask

    // t = clock edges since the edge that sampled Start; n = moves on the stack.
    task automatic check_cycle(input int t, input int n);
        int k;
        k = (t <= 4 * n) ? t / 4 : n;
        chk("pos_x", 32'(Pos_x), 32'(ex[k]));
        chk("pos_y", 32'(Pos_y), 32'(ey[k]));
        chk("step_cnt", 32'(Step_cnt), 32'((k > CMAX) ? CMAX : k));
        chk("edge_err", 32'(Edge_err), 32'(ee[k]));
        chk("pop", 32'(Pop), 32'((t % 4 == 1) && (t < 4 * n)));
        chk("done", 32'(Done), 32'(t == 4 * n + 1));
        chk("busy", 32'(Busy), 32'(t <= 4 * n + 1));
    endtask

    task automatic run(input int x0, input int y0, input bit load_with_start, input bit poke);
        int n;
        n = stack.size();
        Stack_empty = (n == 0);
        build_model(x0, y0);
        if (load_with_start) begin
            Load = 1'b1; Load_x = GW'(x0); Load_y = GW'(y0);
        end
        Start = 1'b1;
        tick();
        Start = 1'b0; Load = 1'b0;
        for (int t = 0; t <= 4 * n + 2; t++) begin
            check_cycle(t, n);
            if (poke && t == 2) begin
                Start = 1'b1; Load = 1'b1;
                Load_x = GW'($urandom); Load_y = GW'($urandom);
            end
            if (t < 4 * n + 2) tick();
            Start = 1'b0; Load = 1'b0;
        end
    endtask

    task automatic fill_random(input int n);
        stack.delete();
        for (int i = 0; i < n; i++) stack.push_back(int'($urandom_range(0, 7)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pos_x"}, 32'(Pos_x), 0);
        chk({tag, "_pos_y"}, 32'(Pos_y), 0);
        chk({tag, "_pop"}, 32'(Pop), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_done"}, 32'(Done), 0);
        chk({tag, "_step"}, 32'(Step_cnt), 0);
        chk({tag, "_err"}, 32'(Edge_err), 0);
    endtask

    initial begin
        // Reset state
        #2;
        check_zero("reset");
        tick(); tick();
        Resetn = 1'b1;
        tick();

        // Load (3,3), stack 0 then 2 (top=2): expect (2,3) then (2,2)
        Load = 1'b1; Load_x = GW'(3); Load_y = GW'(3);
        tick();
        Load = 1'b0;
        stack = {0, 2};
        run(3, 3, 1'b0, 1'b0);

        // West-edge clamp from origin
        stack = {2};
        run(0, 0, 1'b1, 1'b0);

        // Empty stack
        stack.delete();
        run(5, 7, 1'b1, 1'b0);

        // Clamp at the far corner (reverse of W is E, reverse of S is N)
        stack = {4, 6};
        run(GMAX, GMAX, 1'b1, 1'b0);

        // Random walks, with Start/Load poked while busy
        for (int r = 0; r < 5; r++) begin
            fill_random($urandom_range(1, 8));
            run($urandom_range(0, GMAX), $urandom_range(0, GMAX), 1'b1, r[0]);
        end

        // Step counter saturation
        fill_random(CMAX + 3);
        run(16, 16, 1'b1, 1'b0);

        // Abort during the second WAIT
        fill_random(5);
        Stack_empty = 1'b0;
        build_model(9, 20);
        Load = 1'b1; Load_x = GW'(9); Load_y = GW'(20); Start = 1'b1;
        tick();
        Load = 1'b0; Start = 1'b0;
        for (int t = 0; t <= 6; t++) begin
            check_cycle(t, 5);
            if (t < 6) tick();
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_busy", 32'(Busy), 0);
            chk("abort_done", 32'(Done), 0);
            chk("abort_pop", 32'(Pop), 0);
            chk("abort_step", 32'(Step_cnt), 1);
            chk("abort_pos_x", 32'(Pos_x), 32'(ex[1]));
            chk("abort_pos_y", 32'(Pos_y), 32'(ey[1]));
            tick();
        end
        stack.delete();
        Stack_empty = 1'b1;

        // Reset during APPLY
        stack = {1, 3, 5};
        build_model(10, 10);
        Stack_empty = 1'b0;
        Load = 1'b1; Load_x = GW'(10); Load_y = GW'(10); Start = 1'b1;
        tick();
        Load = 1'b0; Start = 1'b0;
        for (int t = 0; t <= 3; t++) begin
            check_cycle(t, 3);
            if (t < 3) tick();
        end
        Resetn = 1'b0;
        #1;
        check_zero("rst_mid");
        tick();
        check_zero("rst_hold");
        Resetn = 1'b1;
        stack.delete();
        Stack_empty = 1'b1;
        tick();
        fill_random(3);
        run(20, 4, 1'b1, 1'b0);

`ifdef BACKTRACK_HOLD_EN
        // Hold parks the FSM in CHECK without popping
        stack = {2};
        Stack_empty = 1'b0;
        Hold = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_pop", 32'(Pop), 0);
            chk("hold_busy", 32'(Busy), 1);
        end
        Hold = 1'b0;
        tick();
        chk("hold_release_pop", 32'(Pop), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("hold_end_busy", 32'(Busy), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
